// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter.
// SHIFTER_STICKY_EN adds the sticky result bit.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
`ifdef SHIFTER_STICKY_EN
    logic               sticky;

    modport master (
        output in_valid, in_data, in_shamt, in_op, flush, out_ready,
        input  in_ready, out_valid, out_data, sticky
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, flush, out_ready,
        output in_ready, out_valid, out_data, sticky
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_op, flush, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, flush, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// log2(WIDTH)-stage barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control.
// SHIFTER_STICKY_EN adds a sticky bit (OR of bits shifted out on SRL/SRA).
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32
) (
    input logic                          clock,
    input logic                          reset_n,
    pipelined_barrel_shifter_if.slave    bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic advance;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int Sh = 1 << i;

        logic               valid_in;
        logic [WIDTH-1:0]   data_in;
        logic [1:0]         op_in;
        logic [SHAMT_W-1:0] shamt_in;
        logic [WIDTH-1:0]   shifted;

        logic               valid_q;
        logic [WIDTH-1:0]   data_q;
        logic [1:0]         op_q;
        logic [SHAMT_W-1:0] shamt_q;

        if (i == 0) begin : g_src
            assign valid_in = bus.in_valid;
            assign data_in  = bus.in_data;
            assign op_in    = bus.in_op;
            assign shamt_in = bus.in_shamt;
        end else begin : g_src
            assign valid_in = g_stage[i-1].valid_q;
            assign data_in  = g_stage[i-1].data_q;
            assign op_in    = g_stage[i-1].op_q;
            assign shamt_in = g_stage[i-1].shamt_q;
        end

        // shamt is pre-shifted each stage, so bit 0 always selects this stage's 2^i step
        always_comb begin
            shifted = data_in;
            if (shamt_in[0]) begin
                case (op_in)
                    2'b00:   shifted = data_in << Sh;
                    2'b01:   shifted = data_in >> Sh;
                    2'b10:   shifted = $signed(data_in) >>> Sh;
                    default: shifted = (data_in >> Sh) | (data_in << (WIDTH - Sh));
                endcase
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                op_q    <= '0;
                shamt_q <= '0;
            end else if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (advance) begin
                valid_q <= valid_in;
                data_q  <= shifted;
                op_q    <= op_in;
                shamt_q <= shamt_in >> 1;
            end
        end

`ifdef SHIFTER_STICKY_EN
        localparam logic [WIDTH-1:0] LowMask = {{(WIDTH - Sh){1'b0}}, {Sh{1'b1}}};

        logic sticky_in;
        logic sticky_nx;
        logic sticky_q;

        if (i == 0) begin : g_sticky_src
            assign sticky_in = 1'b0;
        end else begin : g_sticky_src
            assign sticky_in = g_stage[i-1].sticky_q;
        end

        // op 01 (SRL) and 10 (SRA) are the only right shifts that drop bits
        assign sticky_nx = sticky_in | (shamt_in[0] & (^op_in) & (|(data_in & LowMask)));

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sticky_q <= 1'b0;
            end else if (!bus.flush && advance) begin
                sticky_q <= sticky_nx;
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[SHAMT_W-1].valid_q;
    assign bus.out_data  = g_stage[SHAMT_W-1].data_q;
`ifdef SHIFTER_STICKY_EN
    assign bus.sticky    = g_stage[SHAMT_W-1].sticky_q;
`endif

    // The last stage's op/shamt copies have no consumer.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHAMT_W-1].op_q, g_stage[SHAMT_W-1].shamt_q};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (WIDTH=32): vector table, hand sequences, random scoreboard.
module tb_pipelined_barrel_shifter;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef struct packed {
        logic [31:0] data;
        logic        sticky;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_sticky;
    } vec_t;

    logic clock;
    logic reset_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    bit   mon_en;
    logic prev_stall;
    logic [31:0] prev_data;
    exp_t q[$];
    vec_t vecs[14];

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word shifts on the original operand.
    function automatic exp_t model(input logic [1:0] op, input logic [4:0] s, input logic [31:0] d);
        exp_t        r;
        logic [63:0] dd;
        logic [31:0] mask;
        dd   = {d, d} >> s;
        mask = (32'd1 << s) - 32'd1;
        case (op)
            2'd0:    r.data = d << s;
            2'd1:    r.data = d >> s;
            2'd2:    r.data = $signed(d) >>> s;
            default: r.data = dd[31:0];
        endcase
        r.sticky = (op == 2'd1 || op == 2'd2) && ((d & mask) != 32'd0);
        return r;
    endfunction

    always @(negedge clock) begin
        if (mon_en && reset_n) begin
            exp_t e;
            if (prev_stall) begin
                check("stall hold valid", {63'd0, bus.out_valid}, 64'd1);
                check("stall hold data", {32'd0, bus.out_data}, {32'd0, prev_data});
            end
            check("in_ready rule", {63'd0, bus.in_ready},
                  {63'd0, (!bus.out_valid || bus.out_ready)});
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious out_valid", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("stream data", {32'd0, bus.out_data}, {32'd0, e.data});
`ifdef SHIFTER_STICKY_EN
                    check("stream sticky", {63'd0, bus.sticky}, {63'd0, e.sticky});
`endif
                end
            end
            if (bus.flush) q.delete();
            else if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_op, bus.in_shamt, bus.in_data));
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_data  <= bus.out_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Entered and left at posedge+1.
    task automatic single_op(input string name, input logic [1:0] op, input logic [4:0] s,
                             input logic [31:0] d, input logic [31:0] ed, input logic es);
        int  c0;
        bit  seen;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_shamt  = s;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check({name, " in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        c0   = cyc;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                seen = 1'b1;
                check({name, " latency"}, 64'(cyc - c0 + 1), 64'(SHAMT_W));
                check({name, " data"}, {32'd0, bus.out_data}, {32'd0, ed});
`ifdef SHIFTER_STICKY_EN
                check({name, " sticky"}, {63'd0, bus.sticky}, {63'd0, es});
`endif
            end
        end
        if (!seen) check({name, " timeout"}, 64'd0, {63'd0, bus.out_ready});
        @(posedge clock);
        #1;
        @(negedge clock);
        check({name, " no duplicate"}, {63'd0, bus.out_valid}, 64'd0);
        @(posedge clock);
        #1;
        if (es === 1'bx) $display("unreachable");
    endtask

    task automatic run_stream(input string name, input int n, input bit ramp, input int stall_at,
                              input int stall_len, input int ready_pct, input int valid_pct);
        int issued;
        bit acc;
        issued = 0;
        mon_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (stall_at >= 0 && k >= stall_at && k < stall_at + stall_len)
                bus.out_ready = 1'b0;
            else
                bus.out_ready = ($urandom_range(99) < ready_pct);
            if (!bus.in_valid && issued < n && $urandom_range(99) < valid_pct) begin
                bus.in_valid = 1'b1;
                bus.in_op    = ramp ? 2'($urandom_range(3)) : 2'($urandom_range(3));
                bus.in_shamt = ramp ? 5'(issued) : 5'($urandom_range(31));
                bus.in_data  = $urandom;
            end
            @(negedge clock);
            acc = bus.in_valid && bus.in_ready;
            if (acc) issued++;
            @(posedge clock);
            #1;
            if (acc) bus.in_valid = 1'b0;
            if (issued == n && q.size() == 0) break;
        end
        check({name, " issued"}, 64'(issued), 64'(n));
        check({name, " drained"}, 64'(q.size()), 64'd0);
        mon_en        = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{2'd2, 5'd4,  32'h8000_0000, 32'hF800_0000, 1'b0};
        vecs[1]  = '{2'd0, 5'd31, 32'h0000_00F1, 32'h8000_0000, 1'b0};
        vecs[2]  = '{2'd3, 5'd8,  32'h1234_5678, 32'h7812_3456, 1'b0};
        vecs[3]  = '{2'd1, 5'd0,  32'h8000_0000, 32'h8000_0000, 1'b0};
        vecs[4]  = '{2'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0};
        vecs[5]  = '{2'd1, 5'd4,  32'h0000_001F, 32'h0000_0001, 1'b1};
        vecs[6]  = '{2'd2, 5'd4,  32'h0000_0010, 32'h0000_0001, 1'b0};
        vecs[7]  = '{2'd0, 5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0};
        vecs[8]  = '{2'd2, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{2'd3, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{2'd2, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{2'd3, 5'd31, 32'h0000_0001, 32'h0000_0002, 1'b0};
        vecs[12] = '{2'd2, 5'd16, 32'h8001_0000, 32'hFFFF_8001, 1'b0};
        vecs[13] = '{2'd1, 5'd1,  32'h0000_0003, 32'h0000_0001, 1'b1};

        cyc = 0; n_vec = 0; n_err = 0; mon_en = 1'b0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clock);
        check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset out_data", {32'd0, bus.out_data}, 64'd0);
`ifdef SHIFTER_STICKY_EN
        check("reset sticky", {63'd0, bus.sticky}, 64'd0);
`endif
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("in_ready after reset", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clock);
        #1;

        for (int i = 0; i < 14; i++)
            single_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].data,
                      vecs[i].exp_data, vecs[i].exp_sticky);

        // Back-to-back shamt 0..7 with a 3-cycle consumer stall mid-stream
        run_stream("backpressure", 8, 1'b1, 6, 3, 100, 100);

        // Flush: 3 ops in flight plus one offered in the flush cycle
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 2'($urandom_range(3));
            bus.in_shamt = 5'($urandom_range(31));
            bus.in_data  = $urandom;
            bus.flush    = (i == 3);
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.out_valid) cnt++;
        end
        check("flush outputs", 64'(cnt), 64'd0);
        @(posedge clock);
        #1;
        single_op("post-flush", 2'd3, 5'd8, 32'h1234_5678, 32'h7812_3456, 1'b0);

        // Asynchronous reset with a full, stalled pipeline
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.in_op    = 2'd0;
            bus.in_shamt = 5'd1;
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("full before reset", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("async reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("async reset out_data", {32'd0, bus.out_data}, 64'd0);
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("post-reset out_valid", {63'd0, bus.out_valid}, 64'd0);
            check("post-reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;

        // Random ops, random gaps and backpressure
        run_stream("random", 300, 1'b0, -1, 0, 70, 80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
